// File: rtl/gpll_reconfig_ctrl_if.sv
// APB reconfiguration port between the GPLL sequencer (master) and the
// GTP_GPLL dynamic-reconfiguration block (slave), including its APB reset.
interface gpll_reconfig_ctrl_if;
    logic        rst_n;
    logic        sel;
    logic        en;
    logic        write;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        ready;

    modport master (output rst_n, sel, en, write, addr, wdata, input ready);
    modport slave  (input rst_n, sel, en, write, addr, wdata, output ready);
endinterface

// File: rtl/gpll_reconfig_ctrl.sv
// GPLL reconfiguration sequencer: holds the PLL in reset, replays a register
// table over APB, releases reset, waits for debounced lock and re-locks on loss.
module gpll_reconfig_ctrl #(
    parameter int NUM_REGS     = 8,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_STABLE  = 32,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int APB_TIMEOUT  = 255,
    parameter bit AUTO_RELOCK  = 1'b1,
    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [IDXW:0]        n_regs_i,
    input  logic                 tbl_we_i,
    input  logic [IDXW-1:0]      tbl_idx_i,
    input  logic [4:0]           tbl_addr_i,
    input  logic [15:0]          tbl_data_i,
    input  logic                 pll_lock_i,
    gpll_reconfig_ctrl_if.master apb,
    output logic                 pll_rst_o,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 fail_o,
    output logic                 err_apb_o,
    output logic [7:0]           lol_count_o
);

    localparam int CNT_MAX = (LOCK_TIMEOUT > APB_TIMEOUT)
                           ? ((LOCK_TIMEOUT > RST_CYCLES) ? LOCK_TIMEOUT : RST_CYCLES)
                           : ((APB_TIMEOUT > RST_CYCLES) ? APB_TIMEOUT : RST_CYCLES);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int SW = $clog2(LOCK_STABLE + 1);
    localparam logic [IDXW:0] NMAX = (IDXW+1)'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_HOLD, S_APB_SETUP, S_APB_ACCESS,
        S_REL, S_WAIT_LOCK, S_LOCKED, S_FAIL
    } state_t;

    logic [4:0]  addr_mem [NUM_REGS];
    logic [15:0] data_mem [NUM_REGS];

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]  stab_q, stab_d;
    logic [IDXW:0]  idx_q, idx_d;
    logic [IDXW:0]  nregs_q, nregs_d;
    logic           fail_q, fail_d;
    logic           err_q, err_d;
    logic [7:0]     lol_q, lol_d;
    logic [4:0]     addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic           pll_rst_q, pll_rst_d;
    logic           sel_q, sel_d;
    logic           en_q, en_d;
    logic           ready_q, ready_d;
    logic           busy_q, busy_d;
    logic           apb_rst_n_q;
    logic [1:0]     sync_q;
    logic           lock_s;
    logic [IDXW:0]  n_clamped;

    assign lock_s    = sync_q[1];
    assign n_clamped = (n_regs_i > NMAX) ? NMAX : n_regs_i;

    // The table is only writable while no sequence is replaying it.
    always_ff @(posedge clk) begin
        if (tbl_we_i && !busy_q && (int'(tbl_idx_i) < NUM_REGS)) begin
            addr_mem[tbl_idx_i] <= tbl_addr_i;
            data_mem[tbl_idx_i] <= tbl_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        stab_d  = stab_q;
        idx_d   = idx_q;
        nregs_d = nregs_q;
        fail_d  = fail_q;
        err_d   = err_q;
        lol_d   = lol_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            S_IDLE, S_FAIL: begin
                if (start_i) begin
                    state_d = S_RST_HOLD;
                    fail_d  = 1'b0;
                    err_d   = 1'b0;
                    nregs_d = n_clamped;
                    idx_d   = '0;
                end
            end
            S_RST_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_d == CW'(RST_CYCLES)) begin
                    cnt_d   = '0;
                    state_d = (nregs_q != '0) ? S_APB_SETUP : S_REL;
                end
            end
            S_APB_SETUP: state_d = S_APB_ACCESS;
            S_APB_ACCESS: begin
                if (apb.ready) begin
                    idx_d   = idx_q + (IDXW+1)'(1);
                    state_d = (idx_d == nregs_q) ? S_REL : S_APB_SETUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(APB_TIMEOUT)) begin
                        state_d = S_FAIL;
                        fail_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_REL: begin
                stab_d  = '0;
                state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                cnt_d  = cnt_q + CW'(1);
                stab_d = lock_s ? stab_q + SW'(1) : '0;
                if (lock_s && (stab_d == SW'(LOCK_STABLE))) begin
                    state_d = S_LOCKED;
                end else if (cnt_d == CW'(LOCK_TIMEOUT)) begin
                    state_d = S_FAIL;
                    fail_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            S_LOCKED: begin
                // Loss of lock takes priority over a coincident start request.
                if (!lock_s) begin
                    if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
                    state_d = AUTO_RELOCK ? S_RST_HOLD : S_IDLE;
                    idx_d   = '0;
                end else if (start_i) begin
                    state_d = S_RST_HOLD;
                    nregs_d = n_clamped;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_APB_SETUP) begin
            addr_d  = addr_mem[idx_d[IDXW-1:0]];
            wdata_d = data_mem[idx_d[IDXW-1:0]];
        end

        pll_rst_d = (state_d inside {S_IDLE, S_RST_HOLD, S_APB_SETUP, S_APB_ACCESS, S_FAIL});
        sel_d     = (state_d inside {S_APB_SETUP, S_APB_ACCESS});
        en_d      = (state_d == S_APB_ACCESS);
        ready_d   = (state_d == S_LOCKED);
        busy_d    = (state_d inside {S_RST_HOLD, S_APB_SETUP, S_APB_ACCESS, S_REL, S_WAIT_LOCK});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            stab_q      <= '0;
            idx_q       <= '0;
            nregs_q     <= '0;
            fail_q      <= 1'b0;
            err_q       <= 1'b0;
            lol_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            pll_rst_q   <= 1'b1;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            apb_rst_n_q <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stab_q      <= stab_d;
            idx_q       <= idx_d;
            nregs_q     <= nregs_d;
            fail_q      <= fail_d;
            err_q       <= err_d;
            lol_q       <= lol_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            pll_rst_q   <= pll_rst_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            apb_rst_n_q <= 1'b1;
            sync_q      <= {sync_q[0], pll_lock_i};
        end
    end

    assign apb.rst_n   = apb_rst_n_q;
    assign apb.sel     = sel_q;
    assign apb.en      = en_q;
    assign apb.write   = sel_q;
    assign apb.addr    = addr_q;
    assign apb.wdata   = wdata_q;
    assign pll_rst_o   = pll_rst_q;
    assign ready_o     = ready_q;
    assign busy_o      = busy_q;
    assign fail_o      = fail_q;
    assign err_apb_o   = err_q;
    assign lol_count_o = lol_q;

endmodule

// File: tb/tb_gpll_reconfig_ctrl.sv
// Directed bench for gpll_reconfig_ctrl: table replay, lock debounce, APB and
// lock timeouts, loss-of-lock recovery and mid-transfer reset.
module tb_gpll_reconfig_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, tblWe, pllLock;
    logic [3:0]  nRegs;
    logic [2:0]  tblIdx;
    logic [4:0]  tblAddr;
    logic [15:0] tblData;
    logic        pllRst, ready, busy, fail, errApb;
    logic [7:0]  lolCount;

    int assertCount = 0;
    int failCount   = 0;
    int respMode    = 1;
    int waitCnt     = 0;

    logic [4:0]  expAddr [3];
    logic [15:0] expData [3];

    gpll_reconfig_ctrl_if apbIf();

    gpll_reconfig_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .n_regs_i   (nRegs),
        .tbl_we_i   (tblWe),
        .tbl_idx_i  (tblIdx),
        .tbl_addr_i (tblAddr),
        .tbl_data_i (tblData),
        .pll_lock_i (pllLock),
        .apb        (apbIf),
        .pll_rst_o  (pllRst),
        .ready_o    (ready),
        .busy_o     (busy),
        .fail_o     (fail),
        .err_apb_o  (errApb),
        .lol_count_o(lolCount)
    );

    always #5 clk = ~clk;

    // APB slave model: respMode 1 answers after one wait state, 0 never answers.
    initial begin
        apbIf.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (apbIf.en) waitCnt++;
            else waitCnt = 0;
            apbIf.ready = (respMode == 1) && (waitCnt == 2);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] nr);
        nRegs = nr;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic loadEntry(input logic [2:0] idx, input logic [4:0] a, input logic [15:0] d);
        tblWe = 1'b1; tblIdx = idx; tblAddr = a; tblData = d;
        @(negedge clk);
        tblWe = 1'b0;
    endtask

    task automatic measureLock(input string tag);
        int n;
        n = 0;
        pllLock = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 300);
        checkOutput({tag, "_lock_latency"}, n, 34);
        checkOutput({tag, "_ready"}, ready, 1);
    endtask

    initial begin
        int rstHigh, setups, accesses, okCount, cnt, tog;
        bit selSeen, readySeen;

        expAddr[0] = 5'h01; expData[0] = 16'hA5A5;
        expAddr[1] = 5'h02; expData[1] = 16'h0014;
        expAddr[2] = 5'h03; expData[2] = 16'h0008;
        rst = 1'b1; start = 1'b0; nRegs = '0; tblWe = 1'b0; tblIdx = '0;
        tblAddr = '0; tblData = '0; pllLock = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_pll_rst", pllRst, 1);
        checkOutput("rst_apb_rst_n", apbIf.rst_n, 0);
        checkOutput("rst_sel_en", {apbIf.sel, apbIf.en, apbIf.write}, 0);
        checkOutput("rst_flags", {ready, busy, fail, errApb}, 0);
        checkOutput("rst_addr_data", {apbIf.addr, apbIf.wdata}, 0);
        checkOutput("rst_lol", lolCount, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("apb_rst_n_release", apbIf.rst_n, 1);

        for (int i = 0; i < 3; i++) loadEntry(3'(i), expAddr[i], expData[i]);

        // Three-entry replay with one APB wait state each.
        applyStimulus(4'd3);
        rstHigh = 0; setups = 0; accesses = 0;
        for (int i = 0; i < 200 && pllRst; i++) begin
            rstHigh++;
            if (apbIf.sel && !apbIf.en && setups < 3) begin
                checkOutput($sformatf("t1_setup%0d", setups),
                            {apbIf.write, apbIf.addr, apbIf.wdata},
                            {1'b1, expAddr[setups], expData[setups]});
                setups++;
            end
            if (apbIf.en) accesses++;
            @(negedge clk);
        end
        checkOutput("t1_rst_high_cycles", rstHigh, 25);
        checkOutput("t1_setups", setups, 3);
        checkOutput("t1_accesses", accesses, 6);
        checkOutput("t1_busy_after_rel", busy, 1);
        repeat (100) @(negedge clk);
        measureLock("t1");
        checkOutput("t1_locked_flags", {busy, fail, apbIf.sel}, 0);

        // Restart from LOCKED with an empty table; lock dropped with the request.
        pllLock = 1'b0;
        applyStimulus(4'd0);
        rstHigh = 0; selSeen = 1'b0;
        for (int i = 0; i < 200 && pllRst; i++) begin
            rstHigh++;
            selSeen |= apbIf.sel;
            @(negedge clk);
        end
        checkOutput("t2_rst_high_cycles", rstHigh, 16);
        checkOutput("t2_no_apb", selSeen, 0);
        checkOutput("t2_lol_unchanged", lolCount, 0);
        repeat (10) @(negedge clk);
        measureLock("t2");

        // Loss of lock for five cycles triggers automatic re-lock.
        pllLock = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("t5_ready_dropped", ready, 0);
        checkOutput("t5_busy_relock", busy, 1);
        checkOutput("t5_lol_one", lolCount, 1);
        pllLock = 1'b1;
        for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
        checkOutput("t5_ready_back", ready, 1);
        okCount = 0;
        for (int k = 0; k < 299; k++) begin
            pllLock = 1'b0;
            repeat (5) @(negedge clk);
            pllLock = 1'b1;
            for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
            if (ready) okCount++;
        end
        checkOutput("t5_relocks", okCount, 299);
        checkOutput("t5_lol_saturated", lolCount, 255);

        // APB slave never answers; table writes while busy must be dropped.
        respMode = 0;
        applyStimulus(4'd3);
        loadEntry(3'd0, 5'h1F, 16'hDEAD);
        for (int i = 0; i < 50 && !apbIf.sel; i++) @(negedge clk);
        checkOutput("t3_table_protected", {apbIf.addr, apbIf.wdata}, {5'h01, 16'hA5A5});
        cnt = 0;
        for (int i = 0; i < 400 && !fail; i++) begin
            if (apbIf.en) cnt++;
            @(negedge clk);
        end
        checkOutput("t3_access_cycles", cnt, 255);
        checkOutput("t3_fail_err", {fail, errApb, pllRst}, 3'b111);
        checkOutput("t3_fail_idle", {busy, ready, apbIf.sel, apbIf.en}, 0);
        checkOutput("t3_lol_kept", lolCount, 255);
        respMode = 1;
        applyStimulus(4'd3);
        checkOutput("t3_fail_cleared", {fail, busy}, 2'b01);

        // Reset in the middle of an APB access.
        for (int i = 0; i < 100 && !apbIf.en; i++) @(negedge clk);
        checkOutput("t6_in_access", apbIf.en, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("t6_apb_dropped", {apbIf.sel, apbIf.en}, 0);
        checkOutput("t6_reset_state", {pllRst, apbIf.rst_n, busy, ready, fail}, 5'b10000);
        checkOutput("t6_lol_cleared", lolCount, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_apb_rst_n", apbIf.rst_n, 1);

        // Lock toggling every 20 cycles never debounces; lock timeout fires.
        pllLock = 1'b0;
        applyStimulus(4'd0);
        for (int i = 0; i < 50 && pllRst; i++) @(negedge clk);
        cnt = 1; tog = 0; readySeen = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            @(negedge clk);
            tog++;
            if (tog == 20) begin
                pllLock = ~pllLock;
                tog = 0;
            end
            readySeen |= ready;
            if (pllRst) break;
            cnt++;
        end
        checkOutput("t4_released_cycles", cnt, 65536);
        checkOutput("t4_never_ready", readySeen, 0);
        checkOutput("t4_fail_lock", {fail, errApb, pllRst, busy}, 4'b1010);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
